// File: rtl/iob_cache_line_fill_iob.sv
// Cache line-fill engine: fetches one cache line from the back-end memory,
// one beat per acknowledge, optionally starting at the critical beat and
// wrapping around the line. Each beat is forwarded combinationally to the
// cache data memory, with an early-restart pulse on the critical beat.
module iob_cache_line_fill_iob #(
    parameter int FE_ADDR_W     = 8,
    parameter int FE_DATA_W     = 32,
    parameter int BE_ADDR_W     = 8,
    parameter int BE_DATA_W     = 32,
    parameter int WORD_OFFSET_W = 2,
    parameter int WRAP_EN       = 1,
    localparam int BE_NBYTES_W  = $clog2(BE_DATA_W / 8),
    localparam int LINE2BE_W    = WORD_OFFSET_W - $clog2(BE_DATA_W / FE_DATA_W),
    localparam int RA_W         = FE_ADDR_W - BE_NBYTES_W,
    localparam int BC_W         = (LINE2BE_W > 0) ? LINE2BE_W : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 replace_valid_i,
    input  logic [RA_W-1:0]      replace_addr_i,
    output logic                 replace_o,
    output logic                 read_valid_o,
    output logic [BC_W-1:0]      read_addr_o,
    output logic [BE_DATA_W-1:0] read_rdata_o,
    output logic                 crit_valid_o,
    output logic                 done_o,
    output logic [BE_ADDR_W-1:0] be_addr_o,
    output logic                 be_valid_o,
    input  logic                 be_ack_i,
    input  logic [BE_DATA_W-1:0] be_rdata_i
);

    localparam int LINE_W = RA_W - LINE2BE_W;

    typedef enum logic [1:0] {IDLE, FILL, LAST} state_t;

    state_t              r_state;
    logic [LINE_W-1:0]   r_line;
    logic [BC_W-1:0]     r_beat_cnt;
    logic [BC_W-1:0]     r_beats_left;
    logic [BC_W-1:0]     r_crit;
    logic                r_replace;
    logic                r_be_valid;
    logic                r_done;

    logic [LINE_W-1:0]   w_line;
    logic [BC_W-1:0]     w_crit;
    logic [FE_ADDR_W-1:0] w_fe_addr;
    logic                w_beat_done;

    // Split the request into line and critical beat; a one-beat line has no
    // beat field, so the whole request address is the line.
    generate
        if (LINE2BE_W > 0) begin : g_multi_beat
            assign w_line    = replace_addr_i[RA_W-1:LINE2BE_W];
            assign w_crit    = replace_addr_i[LINE2BE_W-1:0];
            assign w_fe_addr = FE_ADDR_W'({r_line, r_beat_cnt}) << BE_NBYTES_W;
        end else begin : g_single_beat
            assign w_line    = replace_addr_i;
            assign w_crit    = '0;
            assign w_fe_addr = FE_ADDR_W'(r_line) << BE_NBYTES_W;
        end
    endgenerate

    assign w_beat_done  = (r_state == FILL) && be_ack_i;

    assign replace_o    = r_replace;
    assign be_valid_o   = r_be_valid;
    assign done_o       = r_done;
    assign be_addr_o    = BE_ADDR_W'(w_fe_addr);
    assign read_valid_o = w_beat_done;
    assign read_addr_o  = r_beat_cnt;
    assign read_rdata_o = be_rdata_i;
    assign crit_valid_o = w_beat_done && (r_beat_cnt == r_crit);

    // Fill sequencer: accept a line in IDLE, count beats in FILL, then one
    // LAST slot covering the data-memory read latency before going idle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= IDLE;
            r_line       <= '0;
            r_beat_cnt   <= '0;
            r_beats_left <= '0;
            r_crit       <= '0;
            r_replace    <= 1'b0;
            r_be_valid   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (replace_valid_i) begin
                        r_line       <= w_line;
                        r_crit       <= w_crit;
                        r_beat_cnt   <= (WRAP_EN != 0) ? w_crit : '0;
                        r_beats_left <= BC_W'((1 << LINE2BE_W) - 1);
                        r_state      <= FILL;
                        r_replace    <= 1'b1;
                        r_be_valid   <= 1'b1;
                    end
                end
                FILL: begin
                    if (be_ack_i) begin
                        // Beat counter wraps within the line.
                        r_beat_cnt <= (LINE2BE_W == 0) ? '0 : r_beat_cnt + 1'b1;
                        if (r_beats_left == '0) begin
                            r_state    <= LAST;
                            r_be_valid <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_beats_left <= r_beats_left - 1'b1;
                        end
                    end
                end
                LAST: begin
                    r_state   <= IDLE;
                    r_replace <= 1'b0;
                    r_done    <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_replace  <= 1'b0;
                    r_be_valid <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_cache_line_fill_iob.sv
// Bench for the line-fill engine: a wrapping build, a linear build and a
// single-beat build share one stimulus stream; expectations come from the
// beat-order rules (start beat, modulo line length, byte address arithmetic).
module tb_iob_cache_line_fill_iob;

    logic        clk = 1'b0;
    logic        rst;
    logic        rv;
    logic [5:0]  raddr;
    logic        ack;
    logic [31:0] rdata;

    logic        w_rep, w_rvld, w_crit, w_done, w_bev;
    logic [1:0]  w_raddr;
    logic [31:0] w_rdat;
    logic [7:0]  w_bea;
    logic        l_rep, l_rvld, l_crit, l_done, l_bev;
    logic [1:0]  l_raddr;
    logic [31:0] l_rdat;
    logic [7:0]  l_bea;
    logic        s_rep, s_rvld, s_crit, s_done, s_bev;
    logic [0:0]  s_raddr;
    logic [31:0] s_rdat;
    logic [7:0]  s_bea;

    int nchk  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    iob_cache_line_fill_iob #(.WRAP_EN(1)) dut_wrap (
        .clk_i(clk), .reset_i(rst), .replace_valid_i(rv), .replace_addr_i(raddr),
        .replace_o(w_rep), .read_valid_o(w_rvld), .read_addr_o(w_raddr),
        .read_rdata_o(w_rdat), .crit_valid_o(w_crit), .done_o(w_done),
        .be_addr_o(w_bea), .be_valid_o(w_bev), .be_ack_i(ack), .be_rdata_i(rdata));

    iob_cache_line_fill_iob #(.WRAP_EN(0)) dut_lin (
        .clk_i(clk), .reset_i(rst), .replace_valid_i(rv), .replace_addr_i(raddr),
        .replace_o(l_rep), .read_valid_o(l_rvld), .read_addr_o(l_raddr),
        .read_rdata_o(l_rdat), .crit_valid_o(l_crit), .done_o(l_done),
        .be_addr_o(l_bea), .be_valid_o(l_bev), .be_ack_i(ack), .be_rdata_i(rdata));

    iob_cache_line_fill_iob #(.WORD_OFFSET_W(0)) dut_one (
        .clk_i(clk), .reset_i(rst), .replace_valid_i(rv), .replace_addr_i(raddr),
        .replace_o(s_rep), .read_valid_o(s_rvld), .read_addr_o(s_raddr),
        .read_rdata_o(s_rdat), .crit_valid_o(s_crit), .done_o(s_done),
        .be_addr_o(s_bea), .be_valid_o(s_bev), .be_ack_i(ack), .be_rdata_i(rdata));

    // Observation vector: replace, be_valid, read_valid, crit, done,
    // read_addr[1:0], be_addr[7:0], read_rdata[31:0]
    logic [46:0] ow, ol;
    logic [14:0] os;
    assign ow = {w_rep, w_bev, w_rvld, w_crit, w_done, w_raddr, w_bea, w_rdat};
    assign ol = {l_rep, l_bev, l_rvld, l_crit, l_done, l_raddr, l_bea, l_rdat};
    assign os = {s_rep, s_bev, s_rvld, s_crit, s_done, s_raddr, s_bea, 1'b0};

    localparam logic [46:0] M_CTRL   = {5'h1f, 42'h0};
    localparam logic [46:0] M_BEADDR = {7'h0, 8'hff, 32'h0};
    localparam logic [46:0] M_READ   = {5'h0, 2'h3, 8'h0, 32'hffff_ffff};
    localparam logic [46:0] M_RDATA  = {15'h0, 32'hffff_ffff};

    task automatic cmp2(input string tag, input int cyc, input logic [46:0] ew,
                        input logic [46:0] el, input logic [46:0] m);
        nchk++;
        if ((ow & m) !== (ew & m)) begin
            nfail++;
            $display("FAIL %s wrap cyc %0d: got %h want %h", tag, cyc, ow & m, ew & m);
        end
        nchk++;
        if ((ol & m) !== (el & m)) begin
            nfail++;
            $display("FAIL %s linear cyc %0d: got %h want %h", tag, cyc, ol & m, el & m);
        end
    endtask

    // Runs one fill on the wrap and linear builds in lockstep and checks every
    // cycle against the beat-order rules. pat gives acks per FILL cycle; once
    // exhausted, acks are forced high so the fill always terminates.
    task automatic do_fill(input string tag, input logic [5:0] addr, input logic [15:0] pat,
                           input int plen, input bit hold, output int pulses);
        int line, crit, n, cyc, iw, il;
        logic a;
        logic [46:0] ew, el, m;
        line = int'(addr) / 4;
        crit = int'(addr) % 4;
        pulses = 0;
        // request cycle in IDLE, with a stray ack that must be ignored
        @(negedge clk); rv = 1'b1; raddr = addr; ack = 1'b1; rdata = $urandom; #2;
        cmp2({tag, "_req"}, 0, '0, '0, M_CTRL);
        n = 0; cyc = 0;
        while (n < 4 && cyc < 64) begin
            @(negedge clk);
            rv = hold; raddr = 6'($urandom); rdata = $urandom;
            a = (cyc < plen) ? pat[cyc] : 1'b1;
            ack = a; #2;
            iw = (crit + n) % 4;
            il = n;
            ew = {1'b1, 1'b1, a, a && (iw == crit), 1'b0, 2'(iw), 8'((line * 4 + iw) * 4), rdata};
            el = {1'b1, 1'b1, a, a && (il == crit), 1'b0, 2'(il), 8'((line * 4 + il) * 4), rdata};
            m  = M_CTRL | M_BEADDR | (a ? M_READ : 47'h0);
            cmp2({tag, "_fill"}, cyc + 1, ew, el, m);
            if (w_rvld) pulses++;
            if (a) n++;
            cyc++;
        end
        nchk++;
        if (n < 4) begin
            nfail++;
            $display("FAIL %s timeout: beats %0d want 4", tag, n);
        end
        // LAST slot: done, no back-end request, acks ignored
        @(negedge clk); rv = hold; ack = 1'b1; rdata = $urandom; #2;
        cmp2({tag, "_last"}, cyc + 1, {5'b10001, 42'h0}, {5'b10001, 42'h0}, M_CTRL);
        if (w_rvld) pulses++;
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1; rv = 1'b0; ack = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rv = 1'b1; raddr = 6'h3f; ack = 1'b1; rdata = 32'h0;
        #3;
        cmp2("reset", 0, '0, '0, ~M_RDATA);
        nchk++;
        if (os !== 15'h0) begin
            nfail++;
            $display("FAIL reset single got %h want 0", os);
        end
        @(negedge clk); rst = 1'b0; rv = 1'b0; ack = 1'b0;
    endtask

    task automatic test_wrap_fill();
        int p;
        do_fill("wrap", 6'b000110, 16'hffff, 16, 1'b0, p);
        nchk++;
        if (p != 4) begin
            nfail++;
            $display("FAIL wrap_pulses got %0d want 4", p);
        end
    endtask

    task automatic test_ack_gaps();
        int p;
        do_fill("gaps", 6'b101101, 16'h0059, 7, 1'b0, p);
        nchk++;
        if (p != 4) begin
            nfail++;
            $display("FAIL gaps_pulses got %0d want 4", p);
        end
    endtask

    task automatic test_hold();
        int p;
        do_fill("hold1", 6'b011011, 16'h00a5, 8, 1'b1, p);
        do_fill("hold2", 6'b110000, 16'hffff, 16, 1'b1, p);
        @(negedge clk); rv = 1'b0; ack = 1'b0; #2;
        cmp2("hold_idle", 0, '0, '0, M_CTRL);
    endtask

    task automatic test_reset_mid_fill();
        int p;
        @(negedge clk); rv = 1'b1; raddr = 6'b100111; ack = 1'b0;
        @(negedge clk); rv = 1'b0; ack = 1'b1;
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b1; #2;
        cmp2("pre_reset", 3, {5'b11100, 42'h0}, {5'b11100, 42'h0}, M_CTRL);
        rst = 1'b1; #1;
        cmp2("mid_reset", 3, '0, '0, ~M_RDATA);
        @(negedge clk); rst = 1'b0; ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            cmp2("post_reset", i, '0, '0, M_CTRL);
        end
        do_fill("refill", 6'b010001, 16'hffff, 16, 1'b0, p);
    endtask

    task automatic test_single_beat();
        logic [5:0] a;
        a = 6'($urandom);
        pulse_reset();
        @(negedge clk); rv = 1'b1; raddr = a; ack = 1'b0;
        @(negedge clk); rv = 1'b0; raddr = ~a; ack = 1'b0; #2;
        nchk++;
        if ({os[14:10], os[8:1]} !== {5'b11000, 8'(a) << 2}) begin
            nfail++;
            $display("FAIL single_gap got %h want %h", {os[14:10], os[8:1]}, {5'b11000, 8'(a) << 2});
        end
        @(negedge clk); ack = 1'b1; #2;
        nchk++;
        if (os[14:1] !== {5'b11110, 1'b0, 8'(a) << 2}) begin
            nfail++;
            $display("FAIL single_beat got %h want %h", os[14:1], {5'b11110, 1'b0, 8'(a) << 2});
        end
        @(negedge clk); ack = 1'b1; #2;
        nchk++;
        if (os[14:10] !== 5'b10001) begin
            nfail++;
            $display("FAIL single_last got %b want 10001", os[14:10]);
        end
        @(negedge clk); ack = 1'b0; #2;
        nchk++;
        if (os[14:10] !== 5'b00000) begin
            nfail++;
            $display("FAIL single_idle got %b want 00000", os[14:10]);
        end
    endtask

    task automatic test_random();
        int p;
        pulse_reset();
        for (int i = 0; i < 20; i++)
            do_fill("rand", 6'($urandom), 16'($urandom), $urandom_range(0, 16), 1'($urandom), p);
        @(negedge clk); rv = 1'b0; ack = 1'b0;
        @(negedge clk); #2;
        cmp2("rand_idle", 0, '0, '0, M_CTRL);
    endtask

    task automatic test_back_to_back();
        int p;
        for (int i = 0; i < 4; i++)
            do_fill("b2b", 6'($urandom), 16'hffff, 16, 1'b1, p);
        @(negedge clk); rv = 1'b0; ack = 1'b0; #2;
        cmp2("b2b_idle", 0, '0, '0, M_CTRL);
    endtask

    initial begin
        test_reset();
        test_wrap_fill();
        test_ack_gaps();
        test_hold();
        test_reset_mid_fill();
        test_single_beat();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/iob_cache_line_fill_iob.md
IOB_CACHE_LINE_FILL_IOB -- requirements
Module: iob_cache_line_fill_iob

Interface
REQ-001 Parameter FE_ADDR_W, default 8: front-end byte-address width.
REQ-002 Parameter FE_DATA_W, default 32: front-end word width.
REQ-003 Parameter BE_ADDR_W, default 8: back-end byte-address width; SHALL be at least FE_ADDR_W.
REQ-004 Parameter BE_DATA_W, default 32: back-end beat width; SHALL be at least FE_DATA_W.
REQ-005 Parameter WORD_OFFSET_W, default 2: log2 of front-end words per cache line.
REQ-006 Parameter WRAP_EN, default 1: 1 selects critical-beat-first wrapping fill; 0 selects fill from beat 0.
REQ-007 Derived parameters: BE_NBYTES_W = log2(BE_DATA_W/8); LINE2BE_W = WORD_OFFSET_W - log2(BE_DATA_W/FE_DATA_W), which SHALL be at least 0; RA_W = FE_ADDR_W - BE_NBYTES_W.
REQ-008 clk_i  in  1  clock; all state updates on rising edge.
REQ-009 reset_i  in  1  reset, asynchronous, active-high.
REQ-010 replace_valid_i  in  1  line-fill request.
REQ-011 replace_addr_i  in  RA_W  beat address; upper RA_W-LINE2BE_W bits = line, lower LINE2BE_W bits = critical beat.
REQ-012 replace_o  out  1  fill in progress (busy).
REQ-013 read_valid_o  out  1  beat write strobe to the cache data memory.
REQ-014 read_addr_o  out  max(LINE2BE_W,1)  beat index within the line of the current beat.
REQ-015 read_rdata_o  out  BE_DATA_W  beat data.
REQ-016 crit_valid_o  out  1  one-cycle pulse when the critical beat is written (early restart).
REQ-017 done_o  out  1  one-cycle pulse when the fill completes.
REQ-018 be_addr_o  out  BE_ADDR_W  back-end byte address.
REQ-019 be_valid_o  out  1  back-end request.
REQ-020 be_ack_i  in  1  back-end acknowledge with valid be_rdata_i.
REQ-021 be_rdata_i  in  BE_DATA_W  back-end read data.

Function
REQ-022 The state machine SHALL have exactly three states: IDLE, FILL and LAST. LAST is a one-cycle read-latency slot after the final beat.
REQ-023 IDLE: replace_o=0 and be_valid_o=0; replace_valid_i=1 SHALL register the line, set beat_cnt, set beats_left=2^LINE2BE_W-1, and move to FILL.
REQ-024 beat_cnt start value SHALL be the critical beat when WRAP_EN=1, else 0; the critical beat SHALL always be registered for crit_valid_o.
REQ-025 FILL: replace_o=1 and be_valid_o=1.
REQ-026 be_addr_o SHALL be {line, beat_cnt, BE_NBYTES_W zeros}, zero-extended to BE_ADDR_W.
REQ-027 A beat completes in any FILL cycle with be_ack_i=1; in that same cycle read_valid_o=1, read_addr_o=beat_cnt and read_rdata_o=be_rdata_i (combinational, zero added latency).
REQ-028 On each completed beat, beat_cnt SHALL increment modulo 2^LINE2BE_W (wrap-around) and beats_left SHALL decrement.
REQ-029 A completed beat with beats_left=0 SHALL move the machine to LAST.
REQ-030 crit_valid_o SHALL be 1 in the completing cycle whose beat_cnt equals the critical beat; with WRAP_EN=1 this is the first beat.
REQ-031 LAST: replace_o=1, done_o=1, be_valid_o=0 and read_valid_o=0; the next state SHALL be IDLE unconditionally.
REQ-032 replace_valid_i SHALL be ignored in FILL and LAST; the registered line and beat SHALL be unchanged until the next IDLE acceptance.
REQ-033 be_ack_i asserted in IDLE or LAST SHALL be ignored; no strobes are generated.
REQ-034 Back-to-back acks SHALL yield one beat per cycle; ack gaps SHALL hold be_addr_o and beat_cnt stable.
REQ-035 LINE2BE_W=0: exactly one beat; read_addr_o=0; crit_valid_o and read_valid_o SHALL pulse together; WRAP_EN has no effect.
REQ-036 read_valid_o, crit_valid_o and done_o SHALL be 0 whenever be_ack_i=0 or the state is not FILL, except done_o in LAST.
REQ-037 Minimum fill time SHALL be 2^LINE2BE_W+2 cycles from request to return to IDLE.

Reset
REQ-038 reset_i=1 SHALL asynchronously force IDLE and clear the registered line, beat_cnt, beats_left and critical beat to 0.
REQ-039 Under reset, replace_o, be_valid_o, read_valid_o, crit_valid_o and done_o SHALL all be 0.
REQ-040 Reset mid-fill SHALL abort the fill with no done_o; the first request after release SHALL start a fresh fill.

Verification (FE_ADDR_W=8, FE_DATA_W=BE_DATA_W=32, WORD_OFFSET_W=2, so LINE2BE_W=2)
REQ-041 WRAP_EN=1, replace_addr_i=6'b000110, ack every cycle -> be_addr_o 0x18,0x1C,0x10,0x14; read_addr_o 2,3,0,1; crit_valid_o on the first beat; done_o 1 cycle after the 4th ack.
REQ-042 WRAP_EN=0, same address -> be_addr_o 0x10,0x14,0x18,0x1C; crit_valid_o on the 3rd beat only.
REQ-043 Ack pattern 1,0,0,1,1,0,1 -> exactly 4 read_valid_o pulses; be_addr_o held during gaps; be_valid_o=0 in the cycle after the last ack.
REQ-044 replace_valid_i held high throughout a fill with a changing address -> be_addr_o follows only the originally registered line; a new fill starts from IDLE after LAST.
REQ-045 reset_i pulsed after the 2nd ack -> all outputs 0 immediately; no done_o; the next request refills from its own start beat.
REQ-046 LINE2BE_W=0 build (WORD_OFFSET_W=0), one ack -> read_valid_o, crit_valid_o pulse together; done_o the next cycle.
